// File: rtl/cfi_shadow_stack_backend_if.sv
// Log-queue, flush and fault bundle between the CFI queue, the commit
// stage and the shadow-stack backend.
interface cfi_shadow_stack_backend_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned DW   = 5
);
  logic            log_valid_i;
  logic [1:0]      log_type_i;
  logic [XLEN-1:0] log_pc_i;
  logic [XLEN-1:0] log_target_i;
  logic            log_rvc_i;
  logic            log_pop_o;
  logic            flush_i;
  logic            fault_ack_i;
  logic            fault_valid_o;
  logic [63:0]     fault_cause_o;
  logic [XLEN-1:0] fault_tval_o;
  logic [DW-1:0]   depth_o;

  modport slave (
    input  log_valid_i, log_type_i, log_pc_i,
    input  log_target_i, log_rvc_i,
    input  flush_i, fault_ack_i,
    output log_pop_o, fault_valid_o,
    output fault_cause_o, fault_tval_o, depth_o
  );

  modport master (
    output log_valid_i, log_type_i, log_pc_i,
    output log_target_i, log_rvc_i,
    output flush_i, fault_ack_i,
    input  log_pop_o, fault_valid_o,
    input  fault_cause_o, fault_tval_o, depth_o
  );
endinterface

// File: rtl/cfi_shadow_stack_backend.sv
// CFI backend: shadow stack of return addresses checked against every
// committed return, with held fault towards the commit stage.
module cfi_shadow_stack_backend #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned CHECK_LATENCY = 1,
  parameter bit          OVF_WRAP      = 1'b0,
  parameter bit          UNF_FAULT     = 1'b1,
  parameter logic [63:0] FAULT_CAUSE   = 64'd24
) (
  input logic clk_i,
  input logic rst_ni,
  cfi_shadow_stack_backend_if.slave bus
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW =
    (CHECK_LATENCY > 1) ? $clog2(CHECK_LATENCY) : 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [1:0] T_CALL = 2'd2;
  localparam logic [1:0] T_RET  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_FAULT
  } state_t;

  state_t          r_state, w_nstate;
  logic [LW-1:0]   r_cnt;
  logic [1:0]      r_type;
  logic [XLEN-1:0] r_pc, r_tgt, r_tval;
  logic            r_rvc;
  logic [DW-1:0]   r_count;
  logic [PW-1:0]   r_wptr;
  logic [XLEN-1:0] r_stack [DEPTH];

  logic            w_full, w_empty;
  logic [PW-1:0]   w_rdptr, w_wnext;
  logic [XLEN-1:0] w_top, w_ret, w_tval_d;
  logic            w_push, w_spop, w_qpop, w_tval_we;

  assign w_full  = (r_count == FULL);
  assign w_empty = (r_count == '0);
  assign w_rdptr = (r_wptr == '0) ? LAST : r_wptr - PW'(1);
  assign w_wnext = (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
  assign w_top   = r_stack[w_rdptr];
  assign w_ret   = r_pc + (r_rvc ? XLEN'(2) : XLEN'(4));

  always_comb begin
    w_nstate  = r_state;
    w_push    = 1'b0;
    w_spop    = 1'b0;
    w_qpop    = 1'b0;
    w_tval_we = 1'b0;
    w_tval_d  = r_tval;
    unique case (r_state)
      S_IDLE: begin
        if (bus.log_valid_i) w_nstate = S_CHECK;
      end
      S_CHECK: begin
        if (r_cnt == '0) begin
          w_nstate = S_IDLE;
          case (r_type)
            T_CALL: begin
              if (!w_full || OVF_WRAP) begin
                w_push = 1'b1;
                w_qpop = 1'b1;
              end else begin
                w_nstate  = S_FAULT;
                w_tval_we = 1'b1;
                w_tval_d  = r_pc;
              end
            end
            T_RET: begin
              if (w_empty) begin
                if (UNF_FAULT) begin
                  w_nstate  = S_FAULT;
                  w_tval_we = 1'b1;
                  w_tval_d  = r_tgt;
                end else begin
                  w_qpop = 1'b1;
                end
              end else begin
                w_spop = 1'b1;
                if (w_top == r_tgt) begin
                  w_qpop = 1'b1;
                end else begin
                  w_nstate  = S_FAULT;
                  w_tval_we = 1'b1;
                  w_tval_d  = r_tgt;
                end
              end
            end
            default: w_qpop = 1'b1;
          endcase
        end
      end
      S_FAULT: begin
        if (bus.fault_ack_i) begin
          w_qpop   = 1'b1;
          w_nstate = S_IDLE;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_type  <= '0;
      r_pc    <= '0;
      r_tgt   <= '0;
      r_rvc   <= 1'b0;
      r_tval  <= '0;
      r_count <= '0;
      r_wptr  <= '0;
    end else begin
      r_state <= w_nstate;
      if (r_state == S_IDLE && bus.log_valid_i) begin
        r_type <= bus.log_type_i;
        r_pc   <= bus.log_pc_i;
        r_tgt  <= bus.log_target_i;
        r_rvc  <= bus.log_rvc_i;
        r_cnt  <= LW'(CHECK_LATENCY - 1);
      end else if (r_state == S_CHECK && r_cnt != '0) begin
        r_cnt <= r_cnt - LW'(1);
      end
      if (w_tval_we) r_tval <= w_tval_d;
      // a flush overrides any push/pop of the entry being evaluated
      if (bus.flush_i) begin
        r_count <= '0;
        r_wptr  <= '0;
      end else if (w_push) begin
        r_wptr <= w_wnext;
        if (!w_full) r_count <= r_count + DW'(1);
      end else if (w_spop) begin
        r_wptr  <= w_rdptr;
        r_count <= r_count - DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !bus.flush_i) r_stack[r_wptr] <= w_ret;
  end

  assign bus.log_pop_o     = w_qpop;
  assign bus.fault_valid_o = (r_state == S_FAULT);
  assign bus.fault_cause_o =
    (r_state == S_FAULT) ? FAULT_CAUSE : '0;
  assign bus.fault_tval_o  = r_tval;
  assign bus.depth_o       = r_count;

endmodule

// File: tb/tb_cfi_shadow_stack_backend.sv
// Scoreboard bench: four backend configurations fed from modelled
// log queues; a monitor per instance checks every pop.
module tb_cfi_shadow_stack_backend;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [4];

  typedef struct packed {
    logic [1:0]  ty;
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        rvc;
    logic        fl;
  } ent_t;

  typedef struct packed {
    logic        flt;
    logic [63:0] tval;
    logic [31:0] dep;
    logic [31:0] gap;
  } exp_t;

  ent_t inq  [4][$];
  exp_t expq [4][$];

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  for (genvar g = 0; g < 4; g++) begin : u
    localparam int DEP = (g == 0) ? 16 : 4;
    localparam int DW  = $clog2(DEP + 1);

    cfi_shadow_stack_backend_if #(.XLEN(64), .DW(DW)) bus ();

    logic cur_fl = 1'b0;
    logic ack    = 1'b0;
    int   fc     = 0;
    int   last   = 0;
    exp_t me;

    assign bus.flush_i     = cur_fl & bus.log_pop_o;
    assign bus.fault_ack_i = ack;

    cfi_shadow_stack_backend #(
      .XLEN(64),
      .DEPTH(DEP),
      .CHECK_LATENCY((g == 3) ? 3 : 1),
      .OVF_WRAP(g == 2),
      .UNF_FAULT(g != 3),
      .FAULT_CAUSE(64'd24)
    ) dut (
      .clk_i(clk),
      .rst_ni(rst_n[g]),
      .bus(bus)
    );

    // queue model: head entry presented, dropped on the pop strobe
    always @(posedge clk) begin
      if (bus.log_pop_o === 1'b1 && inq[g].size() > 0)
        void'(inq[g].pop_front());
      #1;
      if (inq[g].size() > 0) begin
        bus.log_valid_i  = 1'b1;
        bus.log_type_i   = inq[g][0].ty;
        bus.log_pc_i     = inq[g][0].pc;
        bus.log_target_i = inq[g][0].tgt;
        bus.log_rvc_i    = inq[g][0].rvc;
        cur_fl           = inq[g][0].fl;
      end else begin
        bus.log_valid_i  = 1'b0;
        bus.log_type_i   = 2'd0;
        bus.log_pc_i     = '0;
        bus.log_target_i = '0;
        bus.log_rvc_i    = 1'b0;
        cur_fl           = 1'b0;
      end
    end

    always @(posedge clk) begin
      #1;
      if (ack) ack = 1'b0;
      else if (bus.fault_valid_o === 1'b1) begin
        fc++;
        if (fc == 3) begin
          ack = 1'b1;
          fc  = 0;
        end
      end
    end

    always @(negedge clk) begin
      if (rst_n[g] && bus.log_pop_o === 1'b1) begin
        if (bus.log_valid_i !== 1'b1)
          chk($sformatf("u%0d_pop_no_valid", g), 0, 1);
        if (expq[g].size() == 0) begin
          chk($sformatf("u%0d_unexpected_pop", g), 1, 0);
        end else begin
          me = expq[g].pop_front();
          chk($sformatf("u%0d_fault_valid", g),
              64'(bus.fault_valid_o), 64'(me.flt));
          chk($sformatf("u%0d_cause", g), bus.fault_cause_o,
              me.flt ? 64'd24 : 64'd0);
          if (me.flt)
            chk($sformatf("u%0d_tval", g), bus.fault_tval_o, me.tval);
          if (me.gap != 0)
            chk($sformatf("u%0d_gap", g), 64'(cyc - last), 64'(me.gap));
          last = cyc;
          @(negedge clk);
          chk($sformatf("u%0d_depth", g),
              64'(bus.depth_o), 64'(me.dep));
        end
      end
    end

    initial begin
      #12;
      chk($sformatf("u%0d_rst_pop", g), 64'(bus.log_pop_o), 0);
      chk($sformatf("u%0d_rst_fv", g), 64'(bus.fault_valid_o), 0);
      chk($sformatf("u%0d_rst_cause", g), bus.fault_cause_o, 0);
      chk($sformatf("u%0d_rst_tval", g), bus.fault_tval_o, 0);
      chk($sformatf("u%0d_rst_depth", g), 64'(bus.depth_o), 0);
    end
  end

  localparam logic [1:0] BR = 2'd0, JP = 2'd1, CL = 2'd2, RT = 2'd3;

  task automatic put(int n, logic [1:0] ty, logic [63:0] pc,
                     logic [63:0] tgt, logic rvc, logic fl,
                     logic flt, logic [63:0] tv, int dep, int gap);
    inq[n].push_back('{ty, pc, tgt, rvc, fl});
    expq[n].push_back('{flt, tv, 32'(dep), 32'(gap)});
  endtask

  task automatic drain(int n);
    for (int i = 0; i < 300 && (expq[n].size() != 0 ||
         inq[n].size() != 0); i++)
      @(posedge clk);
    if (expq[n].size() != 0 || inq[n].size() != 0)
      chk($sformatf("u%0d_drain_timeout", n),
          64'(expq[n].size()), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b0;
    #20;
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    @(posedge clk);
    #2;

    put(0, CL, 64'h8000_0000, 0, 0, 0, 0, 0, 1, 0);
    put(0, RT, 0, 64'h8000_0004, 0, 0, 0, 0, 0, 2);
    drain(0);
    put(0, CL, 64'h8000_0010, 0, 1, 0, 0, 0, 1, 0);
    put(0, RT, 0, 64'h8000_0016, 0, 0, 1, 64'h8000_0016, 0, 0);
    drain(0);
    put(0, CL, 64'h4000_0000, 0, 0, 0, 0, 0, 1, 0);
    put(0, CL, 64'h4000_0100, 0, 1, 0, 0, 0, 2, 2);
    put(0, CL, 64'h4000_0200, 0, 0, 1, 0, 0, 0, 2);
    put(0, RT, 0, 64'h4000_0204, 0, 0, 1, 64'h4000_0204, 0, 0);
    drain(0);

    for (int i = 0; i < 4; i++)
      put(1, CL, 64'h1000 + 64'(i) * 64'h100, 0, 0, 0,
          0, 0, i + 1, (i > 0) ? 2 : 0);
    put(1, CL, 64'h1400, 0, 0, 0, 1, 64'h1400, 4, 0);
    drain(1);

    for (int i = 0; i < 5; i++)
      put(2, CL, 64'h2000 + 64'(i) * 64'h100, 0, 0, 0,
          0, 0, (i < 4) ? i + 1 : 4, (i > 0) ? 2 : 0);
    for (int i = 4; i > 0; i--)
      put(2, RT, 0, 64'h2004 + 64'(i) * 64'h100, 0, 0,
          0, 0, i - 1, 2);
    put(2, RT, 0, 64'h2004, 0, 0, 1, 64'h2004, 0, 0);
    drain(2);

    put(3, RT, 0, 64'h3000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      put(3, (i % 2 == 0) ? BR : JP, 64'h3100 + 64'(i),
          64'h3200, 0, 0, 0, 0, 0, 4);
    drain(3);
    put(3, CL, 64'h3300, 0, 0, 0, 0, 0, 1, 0);
    drain(3);

    inq[3].push_back('{CL, 64'h3400, 64'h0, 1'b0, 1'b0});
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("u3_pre_rst_depth", 64'(u[3].bus.depth_o), 1);
    rst_n[3] = 1'b0;
    #1;
    chk("u3_mid_rst_pop", 64'(u[3].bus.log_pop_o), 0);
    chk("u3_mid_rst_fv", 64'(u[3].bus.fault_valid_o), 0);
    chk("u3_mid_rst_cause", u[3].bus.fault_cause_o, 0);
    chk("u3_mid_rst_tval", u[3].bus.fault_tval_o, 0);
    chk("u3_mid_rst_depth", 64'(u[3].bus.depth_o), 0);
    inq[3].delete();
    @(posedge clk);
    #2;
    rst_n[3] = 1'b1;
    repeat (3) @(posedge clk);
    chk("u3_post_rst_depth", 64'(u[3].bus.depth_o), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
